wb_uart_tx: RTL

//  Wishbone B3 classic slave driving the SoC top-level uart_tx pin: the transmit end of the serial link.
//  CPU data-master writes bytes into a TX FIFO.
//  A serializer emits them as 8N1 frames, LSB first, at a programmable baud divisor.

---
 rtl/wb_uart_tx.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_tx.sv
// wb_uart_tx -- Wishbone B3 classic slave that owns the SoC uart_tx pin.
//
// The CPU writes bytes into a TX FIFO through the DATA register. A serializer
// drains the FIFO and sends each byte as an 8N1 frame, LSB first. Each bit
// lasts DIV+1 clocks. A level interrupt reports that the transmitter has gone
// idle with nothing left to send.
//
// Register map (byte address, [3:2] selects the register):
//   0x0 DATA   W  push wb_dat_i[7:0]; reads return 0
//   0x4 STATUS R  [0] full [1] empty [2] busy [3] OVF (cleared by read) [15:8] count
//   0x8 CTRL   RW [15:0] DIV (sel[0]/sel[1]), [16] IE (sel[2])
//   0xC        -  unmapped, answered with wb_err_o
//
// Ports:
//   clk_i, nrst_i        clock, synchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i   Wishbone slave inputs
//   wb_dat_o/ack_o/err_o                    Wishbone slave outputs
//   uart_tx              serial line, idle high
//   irq_o                TX-empty interrupt, level, registered
module wb_uart_tx #(
   parameter int          FIFO_DEPTH  = 16,
   parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic [3:0]  wb_adr_i,
   input  logic [31:0] wb_dat_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_we_i,
   input  logic        wb_cyc_i,
   input  logic        wb_stb_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack_o,
   output logic        wb_err_o,
   output logic        uart_tx,
   output logic        irq_o
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_NONE   = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;

   // Registers visible on the bus
   logic [15:0]   r_div;
   logic          r_ie;
   logic          r_ovf;

   // Bus response
   logic          r_ack;
   logic          r_err;
   logic [31:0]   r_dat;

   // Serializer
   state_t        r_state;
   state_t        w_state_nxt;
   logic [15:0]   r_baud;
   logic [15:0]   w_baud_nxt;
   logic [15:0]   r_div_lat;
   logic [15:0]   w_div_lat_nxt;
   logic [2:0]    r_bitcnt;
   logic [2:0]    w_bitcnt_nxt;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;
   logic          r_tx;
   logic          w_tx_nxt;
   logic          w_pop;

   logic          r_irq;

   // Bus decode
   logic          w_req;
   logic [1:0]    w_reg;
   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic          w_push;
   logic          w_push_ok;
   logic          w_stat_rd;
   logic          w_ctrl_wr;
   logic [7:0]    w_cnt8;
   logic [31:0]   w_rdata;
   logic          w_unused;

   // A request is only taken while no response is pending, so every access
   // completes in two cycles: request, then the registered ack/err.
   assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
   assign w_reg     = wb_adr_i[3:2];
   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_busy    = (r_state != S_IDLE);
   assign w_push    = w_req & wb_we_i & (w_reg == REG_DATA);
   // Full is judged on the registered count, so a pop in the same cycle
   // does not make room for this push.
   assign w_push_ok = w_push & ~w_full;
   assign w_stat_rd = w_req & ~wb_we_i & (w_reg == REG_STATUS);
   assign w_ctrl_wr = w_req & wb_we_i & (w_reg == REG_CTRL);
   assign w_cnt8    = 8'(r_count);

   assign w_unused  = ^{wb_adr_i[1:0], wb_sel_i[3], wb_dat_i[31:17]};

   always_comb begin
      w_rdata = '0;
      case (w_reg)
         REG_STATUS: w_rdata = {16'd0, w_cnt8, 4'd0, r_ovf, w_busy, w_empty, w_full};
         REG_CTRL:   w_rdata = {15'd0, r_ie, r_div};
         default:    w_rdata = '0;
      endcase
   end

   // FIFO storage carries no reset; the pointers define what is valid.
   always_ff @(posedge clk_i) begin
      if (w_push_ok) begin
         r_mem[r_wptr] <= wb_dat_i[7:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_div   <= DEFAULT_DIV;
         r_ie    <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_dat   <= '0;
         r_irq   <= 1'b0;
      end else begin
         if (w_push_ok) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase

         if (w_push & w_full) begin
            r_ovf <= 1'b1;
         end else if (w_stat_rd) begin
            r_ovf <= 1'b0;
         end

         if (w_ctrl_wr) begin
            if (wb_sel_i[0]) r_div[7:0]  <= wb_dat_i[7:0];
            if (wb_sel_i[1]) r_div[15:8] <= wb_dat_i[15:8];
            if (wb_sel_i[2]) r_ie        <= wb_dat_i[16];
         end

         r_ack <= w_req & (w_reg != REG_NONE);
         r_err <= w_req & (w_reg == REG_NONE);
         r_dat <= (w_req & ~wb_we_i) ? w_rdata : '0;

         r_irq <= r_ie & w_empty & ~w_busy;
      end
   end

   // ---- Serializer: next-state logic ----
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud;
      w_bitcnt_nxt  = r_bitcnt;
      w_shift_nxt   = r_shift;
      w_div_lat_nxt = r_div_lat;
      w_pop         = 1'b0;

      unique case (r_state)
         S_IDLE: begin
            // DIV is captured here so a later CTRL write only affects
            // the next frame.
            if (!w_empty) begin
               w_pop         = 1'b1;
               w_shift_nxt   = r_mem[r_rptr];
               w_div_lat_nxt = r_div;
               w_baud_nxt    = r_div;
               w_bitcnt_nxt  = 3'd0;
               w_state_nxt   = S_START;
            end
         end
         S_START: begin
            if (r_baud == 16'd0) begin
               w_baud_nxt  = r_div_lat;
               w_state_nxt = S_DATA;
            end else begin
               w_baud_nxt = r_baud - 1'b1;
            end
         end
         S_DATA: begin
            if (r_baud == 16'd0) begin
               w_baud_nxt = r_div_lat;
               if (r_bitcnt == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_shift_nxt  = {1'b0, r_shift[7:1]};
                  w_bitcnt_nxt = r_bitcnt + 1'b1;
               end
            end else begin
               w_baud_nxt = r_baud - 1'b1;
            end
         end
         S_STOP: begin
            if (r_baud == 16'd0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_baud_nxt = r_baud - 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // The line level is registered from the next state so the pin is
      // glitch-free and goes high on the very edge that applies reset.
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   // ---- Serializer: state register ----
   always_ff @(posedge clk_i) begin
      if (!nrst_i) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bitcnt <= '0;
         r_tx     <= 1'b1;
      end else begin
         r_state  <= w_state_nxt;
         r_baud   <= w_baud_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_tx     <= w_tx_nxt;
      end
   end

   always_ff @(posedge clk_i) begin
      r_shift   <= w_shift_nxt;
      r_div_lat <= w_div_lat_nxt;
   end

   assign wb_dat_o = r_dat;
   assign wb_ack_o = r_ack;
   assign wb_err_o = r_err;
   assign uart_tx  = r_tx;
   assign irq_o    = r_irq;

endmodule
